vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator for the vga_clock design. Replaces the fixed 640x480 counters with one generic engine.
- Generates hsync, vsync, a display-enable signal, pixel coordinates and frame/line strobes for any resolution.
- Adds an internal pixel-clock divider, selectable sync polarity, a run/pause enable and a frame counter.
- Sits between the user-project clock and the pixel-drawing logic inside the Caravel wrapper.

---
 rtl/vga_timing_gen.sv | 86 ++++++++
 tb/tb_vga_timing_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel divider, pause and frame counter
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int CW        = 10,
    parameter int FW        = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_count
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [31:0]   h, v;
    logic          tick, vis, h_last, v_last, hs_on, vs_on;

    // Decode in 32 bits so boundaries equal to 2**CW never truncate
    assign h      = 32'(h_cnt);
    assign v      = 32'(v_cnt);
    assign tick   = enable && (32'(div) == CLK_DIV - 1);
    assign vis    = (h < H_VISIBLE) && (v < V_VISIBLE);
    assign h_last = h == H_TOTAL - 1;
    assign v_last = v == V_TOTAL - 1;
    assign hs_on  = (h >= HS_START) && (h < HS_END);
    assign vs_on  = (v >= VS_START) && (v < VS_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            x           <= '0;
            y           <= '0;
            display_on  <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (enable) div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                display_on  <= vis;
                x           <= vis ? h_cnt : '0;
                y           <= vis ? v_cnt : '0;
                hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
                vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
                line_start  <= h_cnt == '0;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                h_cnt       <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) begin
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                    if (v_last) frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

    assert property (@(posedge clk) (H_TOTAL <= 2**CW) && (V_TOTAL <= 2**CW));
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table and sequence checks on three parameterisations
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // A: small, SYNC_POL=1, FW=2, CLK_DIV=1
    logic rst_a = 1'b0, en_a = 1'b0, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [3:0] x_a, y_a;
    logic [1:0] fc_a;
    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .SYNC_POL(1'b1), .CLK_DIV(1), .CW(4), .FW(2)) dut_a (
        .clk(clk), .reset_n(rst_a), .enable(en_a), .hsync(hs_a), .vsync(vs_a),
        .display_on(de_a), .x(x_a), .y(y_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_count(fc_a));

    // B: CLK_DIV=4, H_TOTAL=16 puts h_cnt at 2**CW-1
    logic rst_b = 1'b0, en_b = 1'b0, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [3:0] x_b, y_b;
    logic [7:0] fc_b;
    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
                     .SYNC_POL(1'b0), .CLK_DIV(4), .CW(4), .FW(8)) dut_b (
        .clk(clk), .reset_n(rst_b), .enable(en_b), .hsync(hs_b), .vsync(vs_b),
        .display_on(de_b), .x(x_b), .y(y_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_count(fc_b));

    // C: defaults, 640x480
    logic rst_c = 1'b0, en_c = 1'b0, hs_c, vs_c, de_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;
    logic [7:0] fc_c;
    vga_timing_gen dut_c (
        .clk(clk), .reset_n(rst_c), .enable(en_c), .hsync(hs_c), .vsync(vs_c),
        .display_on(de_c), .x(x_c), .y(y_c), .line_start(ls_c),
        .frame_start(fs_c), .frame_count(fc_c));

    typedef struct {
        int p;
        int hs, vs, de, x, y, ls, fs, fc;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int pix, lows, first, vlows, bad;
        logic [14:0] e;
        // pixel index p -> h=p%14, v=(p/14)%7; sync active-high at h=10..11, v=5
        tbl = '{
            '{0,   0,0,1,0,0,1,1,0},
            '{1,   0,0,1,1,0,0,0,0},
            '{7,   0,0,1,7,0,0,0,0},
            '{8,   0,0,0,0,0,0,0,0},
            '{10,  1,0,0,0,0,0,0,0},
            '{11,  1,0,0,0,0,0,0,0},
            '{12,  0,0,0,0,0,0,0,0},
            '{14,  0,0,1,0,1,1,0,0},
            '{17,  0,0,1,3,1,0,0,0},
            '{56,  0,0,0,0,0,1,0,0},
            '{70,  0,1,0,0,0,1,0,0},
            '{80,  1,1,0,0,0,0,0,0},
            '{84,  0,0,0,0,0,1,0,0},
            '{98,  0,0,1,0,0,1,1,1},
            '{294, 0,0,1,0,0,1,1,3},
            '{392, 0,0,1,0,0,1,1,0}
        };

        // ---- DUT A: reset state then table ----
        step(2);
        chk("a_reset", {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, fc_a}, 0);
        @(negedge clk);
        rst_a = 1'b1;
        en_a  = 1'b1;
        pix = -1;
        for (int i = 0; i < 16; i++) begin
            while (pix < tbl[i].p) begin
                step(1);
                pix++;
            end
            e = {tbl[i].hs[0], tbl[i].vs[0], tbl[i].de[0], tbl[i].x[3:0], tbl[i].y[3:0],
                 tbl[i].ls[0], tbl[i].fs[0], tbl[i].fc[1:0]};
            chk($sformatf("a_vec%0d_p%0d", i, tbl[i].p),
                {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, fc_a}, 32'(e));
        end
        // async reset while both syncs active (h=10, v=5)
        step(80);
        chk("a_sync_pre", {hs_a, vs_a}, 2'b11);
        #2 rst_a = 1'b0;
        #1 chk("a_async_rst", {hs_a, vs_a, fc_a}, 0);
        @(negedge clk);
        rst_a = 1'b1;
        step(1);
        chk("a_restart", {de_a, x_a, y_a, ls_a, fs_a, fc_a}, {1'b1, 8'd0, 1'b1, 1'b1, 2'd0});

        // ---- DUT B: CLK_DIV=4 ----
        @(negedge clk);
        rst_b = 1'b1;
        en_b  = 1'b1;
        step(3);
        chk("b_no_tick_yet", {hs_b, de_b, ls_b, fs_b}, 4'b1000);
        step(1);
        chk("b_first_tick", {hs_b, de_b, x_b, y_b, ls_b, fs_b}, {2'b11, 8'd0, 2'b11});
        step(1);
        chk("b_strobe_1clk", {de_b, ls_b, fs_b}, 3'b100);
        step(39);
        chk("b_hsync_h10", {hs_b, de_b}, 2'b00);
        step(20);
        chk("b_h15_boundary", {hs_b, de_b, x_b}, {2'b10, 4'd0});
        step(4);
        chk("b_line1", {de_b, x_b, y_b, ls_b, fs_b}, {1'b1, 4'd0, 4'd1, 2'b10});
        step(447);
        chk("b_pre_frame", {ls_b, fs_b}, 2'b00);
        step(1);
        chk("b_frame1", {de_b, x_b, y_b, ls_b, fs_b, fc_b}, {1'b1, 8'd0, 2'b11, 8'd1});
        step(1);
        chk("b_frame1_next", {ls_b, fs_b}, 2'b00);
        // pause mid-divider, resume must not skip or repeat
        step(1);
        en_b = 1'b0;
        step(10);
        chk("b_paused", {x_b, y_b, ls_b, fs_b, de_b}, {8'd0, 2'b00, 1'b1});
        en_b = 1'b1;
        step(1);
        chk("b_resume_wait", x_b, 0);
        step(1);
        chk("b_resume_tick", {x_b, ls_b}, {4'd1, 1'b0});

        // ---- DUT C: defaults ----
        @(negedge clk);
        rst_c = 1'b1;
        en_c  = 1'b1;
        lows = 0; first = -1; vlows = 0;
        for (int p = 0; p < 800; p++) begin
            step(1);
            if (p == 0) chk("c_first", {de_c, x_c, y_c, ls_c, fs_c}, {1'b1, 20'd0, 2'b11});
            if (p == 639) chk("c_h639", {de_c, x_c}, {1'b1, 10'd639});
            if (p == 640) chk("c_h640", {de_c, x_c}, 0);
            if (!hs_c) begin
                lows++;
                if (first < 0) first = p;
            end
            if (!vs_c) vlows++;
        end
        chk("c_hsync_start", first, 656);
        chk("c_hsync_width", lows, 96);
        chk("c_vsync_idle", vlows, 0);
        step(1);
        chk("c_line1", {de_c, x_c, y_c, ls_c, fs_c}, {1'b1, 10'd0, 10'd1, 2'b10});
        // advance to (100,50) = pixel 40100
        step(40100 - 800);
        chk("c_at_100_50", {x_c, y_c, de_c}, {10'd100, 10'd50, 1'b1});
        en_c = 1'b0;
        bad = 0;
        for (int i = 0; i < 37; i++) begin
            step(1);
            if (x_c != 10'd100 || y_c != 10'd50 || !de_c || ls_c || fs_c || !hs_c) bad++;
        end
        chk("c_pause_frozen", bad, 0);
        en_c = 1'b1;
        step(1);
        chk("c_resume", {x_c, y_c}, {10'd101, 10'd50});
        // advance to (300,51) = pixel 41100, then reset mid-line
        step(41100 - 40101);
        chk("c_at_300_51", {x_c, y_c}, {10'd300, 10'd51});
        #2 rst_c = 1'b0;
        #1 chk("c_async_rst", {hs_c, vs_c, de_c, x_c, y_c, fc_c}, {2'b11, 1'b0, 28'd0});
        @(negedge clk);
        rst_c = 1'b1;
        step(1);
        chk("c_restart", {de_c, x_c, y_c, ls_c, fs_c}, {1'b1, 20'd0, 2'b11});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
